// File: rtl/wdata_chan_mngr_pkg.sv
// wdata_chan_mngr_pkg: shared widths, state encodings and state decode for the write data channel manager
package wdata_chan_mngr_pkg;
  localparam int DATA_W = 32;
  localparam int MAX_BEATS = 4;
  localparam int LINE_W = DATA_W * MAX_BEATS;
  localparam int CNT_W = $clog2(MAX_BEATS);
  typedef enum logic [2:0] {
    WDAT_MIDLE = 3'b000,
    WDAT_MSEND = 3'b001,
    WDAT_MLAST = 3'b010,
    WDAT_MDEFO = 3'b111
  } wdat_state_e;
  function automatic wdat_state_e len_state(input logic [CNT_W-1:0] len);
    return len == '0 ? WDAT_MLAST : WDAT_MSEND;
  endfunction
endpackage

// File: rtl/wdata_chan_mngr_if.sv
// wdata_chan_mngr_if: line request, AXI W channel and status signals of the write data manager
interface wdata_chan_mngr_if;
  import wdata_chan_mngr_pkg::*;
  logic wreq_valid;
  logic wreq_ready;
  logic [LINE_W-1:0] wreq_data;
  logic [CNT_W-1:0] wreq_len;
  logic wvalid;
  logic wready;
  logic [DATA_W-1:0] wdata;
  logic wlast;
  logic finish_mwd;
  logic wdat_m_busy;
  modport master(input wreq_valid, wreq_data, wreq_len, wready,
                 output wreq_ready, wvalid, wdata, wlast, finish_mwd, wdat_m_busy);
  modport slave(output wreq_valid, wreq_data, wreq_len, wready,
                input wreq_ready, wvalid, wdata, wlast, finish_mwd, wdat_m_busy);
endinterface

// File: rtl/wdata_req_slot.sv
// wdata_req_slot: one-entry line request register with load/pop and valid/ready
module wdata_req_slot
  import wdata_chan_mngr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic pop,
  input  logic [LINE_W-1:0] din_data,
  input  logic [CNT_W-1:0] din_len,
  output logic valid,
  output logic ready,
  output logic [LINE_W-1:0] data,
  output logic [CNT_W-1:0] len
);
  always_ff @(posedge clk) begin
    valid <= rst ? 1'b0 : load | (valid & ~pop);
    if (load) begin
      data <= din_data;
      len <= din_len;
    end
  end
  assign ready = ~valid;
endmodule

// File: rtl/wdata_chan_mngr.sv
// wdata_chan_mngr: serialises 128-bit write lines into 1-4 beat AXI W bursts with one pending entry
module wdata_chan_mngr
  import wdata_chan_mngr_pkg::*;
(
  input logic clk,
  input logic rst,
  wdata_chan_mngr_if.master bus
);
  wdat_state_e state, state_nx;
  logic [LINE_W-1:0] a_data, p_data;
  logic [CNT_W-1:0] a_len, p_len, cnt;
  logic pvalid, p_ready, hs, done, acc, load_direct, pop, fin;
  assign hs = bus.wvalid & bus.wready;
  assign done = hs & bus.wlast;
  assign acc = bus.wreq_valid & bus.wreq_ready;
  assign load_direct = acc & (state == WDAT_MIDLE | (done & ~pvalid));
  assign pop = done & pvalid;
  wdata_req_slot u_pend (
    .clk(clk), .rst(rst), .load(acc & ~load_direct), .pop(pop),
    .din_data(bus.wreq_data), .din_len(bus.wreq_len),
    .valid(pvalid), .ready(p_ready), .data(p_data), .len(p_len)
  );
  always_comb begin
    state_nx = state == WDAT_MIDLE ? (load_direct ? len_state(bus.wreq_len) : WDAT_MIDLE)
             : state == WDAT_MSEND ? (hs && (cnt + 2'd1) == a_len ? WDAT_MLAST : WDAT_MSEND)
             : state == WDAT_MLAST ? (!done ? WDAT_MLAST : pop ? len_state(p_len)
                                     : load_direct ? len_state(bus.wreq_len) : WDAT_MIDLE)
             : WDAT_MDEFO;
  end
  always_ff @(posedge clk) begin
    state <= rst ? WDAT_MIDLE : state_nx;
    cnt <= rst || done ? '0 : hs ? cnt + 2'd1 : cnt;
    fin <= ~rst & done;
    if (load_direct) begin
      a_data <= bus.wreq_data;
      a_len <= bus.wreq_len;
    end else if (pop) begin
      a_data <= p_data;
      a_len <= p_len;
    end
  end
  assign bus.wreq_ready = p_ready;
  assign bus.wvalid = state == WDAT_MSEND | state == WDAT_MLAST;
  assign bus.wlast = state == WDAT_MLAST;
  assign bus.wdata = bus.wvalid ? a_data[{cnt, 5'd0} +: DATA_W] : '0;
  assign bus.finish_mwd = fin;
  assign bus.wdat_m_busy = state != WDAT_MIDLE | pvalid;
endmodule

// File: tb/tb_wdata_chan_mngr.sv
// tb_wdata_chan_mngr: directed checks of burst serialisation, stalls, back-to-back, backpressure and reset
module tb_wdata_chan_mngr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [127:0] line;
  logic [127:0] la, lb, lc, ld;
  logic wr_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int beat_idx [6] = '{0, 1, 1, 1, 2, 3};
  always #5 clk = ~clk;
  wdata_chan_mngr_if bus();
  wdata_chan_mngr dut(.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic req(input logic [127:0] d, input logic [1:0] l);
    bus.wreq_valid = 1'b1;
    bus.wreq_data = d;
    bus.wreq_len = l;
  endtask
  initial begin
    bus.wreq_valid = 1'b0;
    bus.wreq_data = '0;
    bus.wreq_len = '0;
    bus.wready = 1'b0;
    line = 128'h44444444_33333333_22222222_11111111;
    la = 128'hA0000003_A0000002_A0000001_A0000000;
    lb = 128'h00000000_00000000_B0000001_B0000000;
    lc = 128'h00000000_00000000_00000000_C0000000;
    ld = 128'h00000000_00000000_D0000001_D0000000;
    repeat (2) nxt;
    rst = 1'b0;
    smp;
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_wlast", bus.wlast, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_finish", bus.finish_mwd, 0);
    chk("rst_ready", bus.wreq_ready, 1);
    chk("rst_busy", bus.wdat_m_busy, 0);
    // single 4-beat burst, wready always high
    nxt;
    req(line, 2'd3);
    bus.wready = 1'b1;
    smp;
    chk("b1_ready", bus.wreq_ready, 1);
    nxt;
    bus.wreq_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp;
      chk("b1_wvalid", bus.wvalid, 1);
      chk("b1_wdata", bus.wdata, line[k*32 +: 32]);
      chk("b1_wlast", bus.wlast, 32'(k == 3));
      nxt;
    end
    smp;
    chk("b1_finish", bus.finish_mwd, 1);
    chk("b1_idle_wvalid", bus.wvalid, 0);
    chk("b1_idle_busy", bus.wdat_m_busy, 0);
    nxt;
    smp;
    chk("b1_finish_off", bus.finish_mwd, 0);
    // stall on beat 1 for two cycles
    nxt;
    req(line, 2'd3);
    bus.wready = 1'b0;
    nxt;
    bus.wreq_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.wready = wr_pat[i];
      smp;
      chk("st_wvalid", bus.wvalid, 1);
      chk("st_wdata", bus.wdata, line[beat_idx[i]*32 +: 32]);
      chk("st_wlast", bus.wlast, 32'(i == 5));
      chk("st_finish_early", bus.finish_mwd, 0);
      nxt;
    end
    smp;
    chk("st_finish", bus.finish_mwd, 1);
    nxt;
    smp;
    chk("st_finish_off", bus.finish_mwd, 0);
    chk("st_wvalid_off", bus.wvalid, 0);
    // single-beat burst
    nxt;
    bus.wready = 1'b1;
    req(128'h0000000000000000_00000000DEADBEEF, 2'd0);
    nxt;
    bus.wreq_valid = 1'b0;
    smp;
    chk("sb_wvalid", bus.wvalid, 1);
    chk("sb_wlast", bus.wlast, 1);
    chk("sb_wdata", bus.wdata, 32'hDEADBEEF);
    nxt;
    smp;
    chk("sb_finish", bus.finish_mwd, 1);
    chk("sb_wvalid_off", bus.wvalid, 0);
    chk("sb_busy", bus.wdat_m_busy, 0);
    nxt;
    smp;
    chk("sb_finish_off", bus.finish_mwd, 0);
    // back-to-back A, B pending, C held off until B moves to active
    nxt;
    req(la, 2'd3);
    nxt;
    bus.wreq_valid = 1'b0;
    smp;
    chk("bb_a0", bus.wdata, 32'hA0000000);
    nxt;
    req(lb, 2'd1);
    smp;
    chk("bb_a1", bus.wdata, 32'hA0000001);
    chk("bb_ready_a1", bus.wreq_ready, 1);
    nxt;
    req(lc, 2'd0);
    smp;
    chk("bb_a2", bus.wdata, 32'hA0000002);
    chk("bb_ready_pend", bus.wreq_ready, 0);
    chk("bb_busy", bus.wdat_m_busy, 1);
    nxt;
    smp;
    chk("bb_a3", bus.wdata, 32'hA0000003);
    chk("bb_a3_last", bus.wlast, 1);
    chk("bb_ready_a3", bus.wreq_ready, 0);
    nxt;
    smp;
    chk("bb_b0", bus.wdata, 32'hB0000000);
    chk("bb_b0_valid", bus.wvalid, 1);
    chk("bb_b0_last", bus.wlast, 0);
    chk("bb_fin_a", bus.finish_mwd, 1);
    chk("bb_ready_free", bus.wreq_ready, 1);
    nxt;
    bus.wreq_valid = 1'b0;
    smp;
    chk("bb_b1", bus.wdata, 32'hB0000001);
    chk("bb_b1_last", bus.wlast, 1);
    chk("bb_fin_gap", bus.finish_mwd, 0);
    chk("bb_ready_c", bus.wreq_ready, 0);
    nxt;
    smp;
    chk("bb_c0", bus.wdata, 32'hC0000000);
    chk("bb_c0_last", bus.wlast, 1);
    chk("bb_fin_b", bus.finish_mwd, 1);
    chk("bb_busy_c", bus.wdat_m_busy, 1);
    nxt;
    smp;
    chk("bb_fin_c", bus.finish_mwd, 1);
    chk("bb_idle", bus.wvalid, 0);
    chk("bb_busy_off", bus.wdat_m_busy, 0);
    // reset during beat 2 with a pending entry
    nxt;
    req(la, 2'd3);
    nxt;
    req(lb, 2'd1);
    nxt;
    bus.wreq_valid = 1'b0;
    smp;
    chk("rm_a1", bus.wdata, 32'hA0000001);
    chk("rm_ready_pend", bus.wreq_ready, 0);
    nxt;
    smp;
    chk("rm_a2", bus.wdata, 32'hA0000002);
    nxt;
    rst = 1'b1;
    nxt;
    rst = 1'b0;
    smp;
    chk("rm_wvalid", bus.wvalid, 0);
    chk("rm_ready", bus.wreq_ready, 1);
    chk("rm_busy", bus.wdat_m_busy, 0);
    chk("rm_finish", bus.finish_mwd, 0);
    nxt;
    req(ld, 2'd1);
    nxt;
    bus.wreq_valid = 1'b0;
    smp;
    chk("rm_new_d0", bus.wdata, 32'hD0000000);
    chk("rm_new_valid", bus.wvalid, 1);
    chk("rm_new_fin", bus.finish_mwd, 0);
    nxt;
    smp;
    chk("rm_new_d1", bus.wdata, 32'hD0000001);
    chk("rm_new_last", bus.wlast, 1);
    nxt;
    smp;
    chk("rm_new_finish", bus.finish_mwd, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
